// File: rtl/queue_pkg.sv
// Shared types and constants for the queue frame reader: FSM encoding, header layout and
// helpers used to build frame headers.
package queue_pkg;

   typedef logic [1:0] qfr_state_t;

   localparam qfr_state_t IDLE    = 2'd0;
   localparam qfr_state_t HEADER  = 2'd1;
   localparam qfr_state_t PAYLOAD = 2'd2;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   localparam int unsigned HDR_SYNC_LSB = 24;
   localparam int unsigned HDR_SEQ_LSB  = 16;
   localparam int unsigned HDR_LEN_LSB  = 0;
   localparam int unsigned HDR_LEN_W    = 16;

   function automatic logic [31:0] min_len(input logic [31:0] count, input logic [31:0] max);
      return (count < max) ? count : max;
   endfunction

   function automatic logic [31:0] make_header(input logic [7:0]  sync,
                                               input logic [7:0]  seq,
                                               input logic [15:0] len);
      logic [31:0] hdr;
      hdr = '0;
      hdr[HDR_SYNC_LSB +: 8]        = sync;
      hdr[HDR_SEQ_LSB +: 8]         = seq;
      hdr[HDR_LEN_LSB +: HDR_LEN_W] = len;
      return hdr;
   endfunction

endpackage

// File: rtl/qfr_out_reg.sv
// Output register for the frame reader: holds a word under backpressure and exposes the
// load slot in which the next word may be written.
module qfr_out_reg #(
   parameter int DATA_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [DATA_SIZE-1:0] load_data,
   input  logic                 load_last,
   input  logic                 out_ready,
   output logic                 load_slot,
   output logic                 out_valid,
   output logic [DATA_SIZE-1:0] out_data,
   output logic                 out_last
);

   assign load_slot = !out_valid || out_ready;

   // Outside a load slot everything holds; a slot without a load empties the register but
   // keeps the last data word so the bus does not toggle needlessly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load_slot) begin
         out_valid <= load;
         if (load) begin
            out_data <= load_data;
            out_last <= load_last;
         end else begin
            out_last <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/queue_frame_reader.sv
// Drains a show-ahead FIFO and emits framed bursts (header + 1..MAX_BURST payload words)
// on a valid/ready stream.
module queue_frame_reader
   import queue_pkg::*;
#(
   parameter int         DATA_SIZE = 32,
   parameter int         FIFO_SIZE = 1024,
   parameter int         CNT_WIDTH = $clog2(FIFO_SIZE) + 1,
   parameter int         MAX_BURST = 16,
   parameter int         TIMEOUT   = 64,
   parameter logic [7:0] SYNC      = SYNC_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 q_empty,
   input  logic [CNT_WIDTH-1:0] q_count,
   input  logic [DATA_SIZE-1:0] q_pop_data,
   output logic                 q_pop,
   output logic                 out_valid,
   output logic [DATA_SIZE-1:0] out_data,
   output logic                 out_last,
   input  logic                 out_ready,
   output logic                 busy,
   output logic [7:0]           seq,
   output logic                 err
);

   localparam int LEN_W = HDR_LEN_W;
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BURST);
   localparam logic [TMR_W-1:0]     TMR_MAX = TMR_W'(TIMEOUT);

   qfr_state_t       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [7:0]       seq_q, seq_d;
   logic             err_q, err_d;

   logic                 load;
   logic [DATA_SIZE-1:0] load_data;
   logic                 load_last;
   logic                 load_slot;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      rem_d     = rem_q;
      timer_d   = timer_q;
      seq_d     = seq_q;
      err_d     = err_q;
      load      = 1'b0;
      load_data = '0;
      load_last = 1'b0;
      q_pop     = 1'b0;

      case (state_q)
         IDLE: begin
            if (q_empty) begin
               timer_d = '0;
            end else if (q_count < MAX_CNT && timer_q != TMR_MAX) begin
               timer_d = timer_q + TMR_W'(1);
            end
            // Length is latched here only; pushes during the frame never stretch it.
            if (enable && !q_empty && (q_count >= MAX_CNT || timer_q == TMR_MAX)) begin
               len_d   = LEN_W'(min_len(32'(q_count), 32'(MAX_BURST)));
               rem_d   = LEN_W'(min_len(32'(q_count), 32'(MAX_BURST)));
               timer_d = '0;
               state_d = HEADER;
            end
         end

         HEADER: begin
            if (load_slot) begin
               load      = 1'b1;
               load_data = DATA_SIZE'(make_header(SYNC, seq_q, len_q));
               seq_d     = seq_q + 8'd1;
               state_d   = PAYLOAD;
            end
         end

         PAYLOAD: begin
            if (load_slot) begin
               if (!q_empty && rem_q != '0) begin
                  load      = 1'b1;
                  q_pop     = 1'b1;
                  load_data = q_pop_data;
                  load_last = (rem_q == LEN_W'(1));
                  rem_d     = rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state_d = IDLE;
                  end
               end else if (q_empty) begin
                  // Underrun: stay in the frame and wait for data to return.
                  err_d = 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         rem_q   <= '0;
         timer_q <= '0;
         seq_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         timer_q <= timer_d;
         seq_q   <= seq_d;
         err_q   <= err_d;
      end
   end

   qfr_out_reg #(
      .DATA_SIZE(DATA_SIZE)
   ) u_out_reg (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_data(load_data),
      .load_last(load_last),
      .out_ready(out_ready),
      .load_slot(load_slot),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_last (out_last)
   );

   assign busy = (state_q != IDLE);
   assign seq  = seq_q;
   assign err  = err_q;

endmodule

// File: tb/tb_queue_frame_reader.sv
// Directed bench for queue_frame_reader: a behavioural show-ahead queue feeds the DUT and a
// monitor records every output transfer for comparison against hand-computed frames.
module tb_queue_frame_reader;

   localparam int CNT_WIDTH = 11;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 enable;
   logic                 q_empty;
   logic [CNT_WIDTH-1:0] q_count;
   logic [31:0]          q_pop_data;
   logic                 q_pop;
   logic                 out_valid;
   logic [31:0]          out_data;
   logic                 out_last;
   logic                 out_ready;
   logic                 busy;
   logic [7:0]           seq;
   logic                 err;

   always #5 clk = ~clk;

   queue_frame_reader #(
      .DATA_SIZE(32),
      .FIFO_SIZE(1024),
      .CNT_WIDTH(CNT_WIDTH),
      .MAX_BURST(16),
      .TIMEOUT  (64),
      .SYNC     (8'hA5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .q_empty   (q_empty),
      .q_count   (q_count),
      .q_pop_data(q_pop_data),
      .q_pop     (q_pop),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy),
      .seq       (seq),
      .err       (err)
   );

   // Queue model
   logic [31:0] mem [0:1023];
   int          wr_ptr      = 0;
   int          rd_ptr      = 0;
   logic        force_empty = 1'b0;
   int          n_pop       = 0;
   int          n_pop_empty = 0;
   int          cyc         = 0;

   always_comb begin
      q_empty    = force_empty || (wr_ptr == rd_ptr);
      q_count    = force_empty ? '0 : CNT_WIDTH'(wr_ptr - rd_ptr);
      q_pop_data = mem[rd_ptr % 1024];
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (q_pop) begin
         if (q_empty) begin
            n_pop_empty <= n_pop_empty + 1;
         end else begin
            rd_ptr <= rd_ptr + 1;
            n_pop  <= n_pop + 1;
         end
      end
   end

   // Transfer monitor and stall-stability tracker
   logic [31:0] cap_data [0:511];
   logic        cap_last [0:511];
   int          cap_cyc  [0:511];
   int          n_cap      = 0;
   int          n_viol     = 0;
   logic        stall_prev = 1'b0;
   logic [31:0] data_prev  = '0;

   always @(negedge clk) begin
      if (out_valid && out_ready && !reset && n_cap < 512) begin
         cap_data[n_cap] <= out_data;
         cap_last[n_cap] <= out_last;
         cap_cyc[n_cap]  <= cyc;
         n_cap           <= n_cap + 1;
      end
      if (stall_prev && !(out_valid && out_data == data_prev)) n_viol <= n_viol + 1;
      stall_prev <= out_valid && !out_ready && !reset;
      data_prev  <= out_data;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d);
      mem[wr_ptr % 1024] = d;
      wr_ptr++;
   endtask

   task automatic wait_caps(input int target, input int bound, input string tag);
      int k = 0;
      while (n_cap < target && k < bound) begin
         @(posedge clk);
         k++;
      end
      @(negedge clk);
      chk(tag, 64'(n_cap >= target), 64'd1);
   endtask

   task automatic check_frame(input string tag, input int b, input logic [31:0] hdr,
                              input logic [31:0] first, input int n);
      int lasts = 0;
      chk({tag, "_hdr"}, cap_data[b], hdr);
      chk({tag, "_hdr_last"}, cap_last[b], 0);
      for (int i = 1; i <= n; i++) begin
         chk($sformatf("%s_payload[%0d]", tag, i - 1), cap_data[b + i], first + 32'(i - 1));
         if (cap_last[b + i]) lasts++;
      end
      chk({tag, "_last_pos"}, cap_last[b + n], 1);
      chk({tag, "_last_count"}, lasts, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b;
      int p0;
      int e0;
      int v0;
      int k;

      reset     = 1'b1;
      enable    = 1'b1;
      out_ready = 1'b1;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_q_pop", q_pop, 0);
      chk("rst_busy", busy, 0);
      chk("rst_seq", seq, 0);
      chk("rst_err", err, 0);

      // Full 16-word burst, header latency and back-to-back payload beats
      for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
      b  = n_cap;
      p0 = n_pop;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("t1_busy_after_start", busy, 1);
      chk("t1_no_valid_yet", out_valid, 0);
      @(posedge clk); #1;
      chk("t1_hdr_valid", out_valid, 1);
      chk("t1_hdr_data", out_data, 32'hA500_0010);
      chk("t1_seq_incr", seq, 1);
      wait_caps(b + 17, 100, "t1_done");
      check_frame("t1", b, 32'hA500_0010, 32'h100, 16);
      chk("t1_pops", n_pop - p0, 16);
      chk("t1_throughput", cap_cyc[b + 16] - cap_cyc[b], 16);
      repeat (3) @(posedge clk);
      #1;
      chk("t1_idle", busy, 0);

      // Short queue waits for the timeout before a partial frame
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) push(32'h200 + 32'(i));
      b = n_cap;
      repeat (64) @(posedge clk);
      #1;
      chk("t2_no_early_start", busy, 0);
      @(posedge clk); #1;
      chk("t2_start_at_timeout", busy, 1);
      wait_caps(b + 4, 50, "t2_done");
      check_frame("t2", b, 32'hA501_0003, 32'h200, 3);

      // 40 words: two full frames then an 8-word frame after the timeout
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      #1;
      chk("t3_seq_cleared", seq, 0);
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++) push(32'h300 + 32'(i));
      b  = n_cap;
      p0 = n_pop;
      wait_caps(b + 43, 400, "t3_done");
      check_frame("t3a", b, 32'hA500_0010, 32'h300, 16);
      check_frame("t3b", b + 17, 32'hA501_0010, 32'h310, 16);
      check_frame("t3c", b + 34, 32'hA502_0008, 32'h320, 8);
      chk("t3_pops", n_pop - p0, 40);

      // Random backpressure during a 16-word frame
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) push(32'h400 + 32'(i));
      b  = n_cap;
      p0 = n_pop;
      v0 = n_viol;
      k  = 0;
      while (n_cap < b + 17 && k < 600) begin
         @(posedge clk); #1;
         out_ready = 1'($urandom_range(0, 1));
         k++;
      end
      out_ready = 1'b1;
      wait_caps(b + 17, 10, "t4_done");
      check_frame("t4", b, 32'hA503_0010, 32'h400, 16);
      chk("t4_stall_stable", n_viol - v0, 0);
      chk("t4_pops", n_pop - p0, 16);
      repeat (3) @(posedge clk);

      // Reset on the 5th payload beat abandons the frame
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) push(32'h500 + 32'(i));
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(out_valid && out_data == 32'h504) && k < 100);
      chk("t5_reached_beat5", out_data, 32'h504);
      #1 reset = 1'b1;
      #1;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_out_data", out_data, 0);
      chk("t5_out_last", out_last, 0);
      chk("t5_q_pop", q_pop, 0);
      chk("t5_busy", busy, 0);
      chk("t5_seq", seq, 0);
      chk("t5_err", err, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("t5_queue_left", wr_ptr - rd_ptr, 11);
      b = n_cap;
      wait_caps(b + 12, 200, "t5_done");
      check_frame("t5", b, 32'hA500_000B, 32'h505, 11);
      chk("t5_seq_after", seq, 1);

      // Underrun with 4 words remaining
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) push(32'h600 + 32'(i));
      b  = n_cap;
      p0 = n_pop;
      e0 = n_pop_empty;
      k  = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(out_valid && out_data == 32'h60A) && k < 100);
      @(posedge clk); #1;
      force_empty = 1'b1;
      chk("t6_err_before", err, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("t6_err_set", err, 1);
      chk("t6_valid_dropped", out_valid, 0);
      chk("t6_still_busy", busy, 1);
      chk("t6_no_pop", q_pop, 0);
      force_empty = 1'b0;
      wait_caps(b + 17, 50, "t6_done");
      check_frame("t6", b, 32'hA501_0010, 32'h600, 16);
      chk("t6_pops", n_pop - p0, 16);
      chk("t6_pop_while_empty", n_pop_empty - e0, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("t6_err_sticky", err, 1);

      // enable low: no new frame even with a full queue
      enable = 1'b0;
      for (int i = 0; i < 20; i++) push(32'h700 + 32'(i));
      b  = n_cap;
      p0 = n_pop;
      repeat (80) @(posedge clk);
      #1;
      chk("t7_disabled_idle", busy, 0);
      chk("t7_no_output", n_cap - b, 0);
      chk("t7_no_pops", n_pop - p0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
